// File: rtl/vram_bank_ctrl.sv
// ============================================================================
// vram_bank_ctrl : banked multi-plane VRAM with CPU/clear port and video port.
// Optional clear engine enabled by macro VRAM_BANK_CTRL_CLEAR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vram_bank_ctrl #(
    parameter int         PLANES  = 6,
    parameter int         AW      = 13,
    parameter logic [7:0] IO_BASE = 8'hF1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  io_wr,
    input  logic                  io_rd,
    input  logic [7:0]            io_addr,
    input  logic [7:0]            io_din,
    output logic [7:0]            io_dout,
    input  logic                  mem_sel,
    input  logic                  mem_wr,
    input  logic [AW-1:0]         mem_addr,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    input  logic [AW-1:0]         vaddr,
    output logic [8*PLANES-1:0]   vdata,
    output logic                  busy
);

    localparam logic [7:0] c_port_bank = IO_BASE;
    localparam logic [7:0] c_port_mask = IO_BASE + 8'd1;
    localparam logic [7:0] c_port_stat = IO_BASE + 8'd2;

    logic [7:0]              r_rd_bank;
    logic [PLANES-1:0]       r_wr_mask;
    logic [7:0]              r_io_dout;
    logic [7:0]              r_rd_sel;
    logic                    w_busy;
    logic [AW-1:0]           w_clr_addr;
    logic [7:0]              w_fill;
    logic [PLANES-1:0]       w_clr_mask;
    logic [PLANES-1:0][7:0]  w_a_q;
    logic [7:0]              w_mem_dout;

    // Bank/mask registers, I/O readback and pending CPU read bank (0 = none)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_bank <= 8'd0;
            r_wr_mask <= '0;
            r_io_dout <= 8'hFF;
            r_rd_sel  <= 8'd0;
        end else begin
            if (io_wr && io_addr == c_port_bank)
                r_rd_bank <= io_din;
            if (io_wr && io_addr == c_port_mask)
                r_wr_mask <= io_din[PLANES-1:0];
            if (io_rd) begin
                if (io_addr == c_port_bank)
                    r_io_dout <= r_rd_bank;
                else if (io_addr == c_port_mask)
                    r_io_dout <= 8'(r_wr_mask);
                else if (io_addr == c_port_stat)
                    r_io_dout <= {w_busy, 7'b0};
                else
                    r_io_dout <= 8'hFF;
            end
            r_rd_sel <= (mem_sel && !mem_wr && !w_busy) ? r_rd_bank : 8'd0;
        end
    end

`ifdef VRAM_BANK_CTRL_CLEAR_EN
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_cnt;
    logic [7:0]        r_fill;
    logic [PLANES-1:0] r_clr_mask;
    logic              r_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_fill     <= 8'd0;
            r_clr_mask <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_wr && io_addr == c_port_stat) begin
                        r_state    <= S_FILL;
                        r_fill     <= io_din;
                        r_clr_mask <= r_wr_mask;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                S_FILL: begin
                    r_cnt <= r_cnt + AW'(1);
                    if (&r_cnt) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign w_busy     = r_busy;
    assign w_clr_addr = r_cnt;
    assign w_fill     = r_fill;
    assign w_clr_mask = r_clr_mask;
`else
    assign w_busy     = 1'b0;
    assign w_clr_addr = '0;
    assign w_fill     = 8'd0;
    assign w_clr_mask = '0;
`endif

    // Port A is owned by the clear engine while busy; port B is video only
    for (genvar g = 0; g < PLANES; g++) begin : g_plane
        logic [7:0]    r_mem [0:(1<<AW)-1];
        logic [7:0]    r_a_q;
        logic [7:0]    r_v_q;
        logic          w_we;
        logic [AW-1:0] w_a_addr;
        logic [7:0]    w_a_din;

        assign w_we     = w_busy ? w_clr_mask[g] : (mem_sel && mem_wr && r_wr_mask[g]);
        assign w_a_addr = w_busy ? w_clr_addr : mem_addr;
        assign w_a_din  = w_busy ? w_fill : mem_din;

        always_ff @(posedge clk) begin
            if (w_we)
                r_mem[w_a_addr] <= w_a_din;
            r_a_q <= r_mem[w_a_addr];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                r_v_q <= 8'd0;
            else
                r_v_q <= r_mem[vaddr];
        end

        assign vdata[8*g +: 8] = r_v_q;
        assign w_a_q[g]        = r_a_q;
    end

    always_comb begin
        w_mem_dout = 8'hFF;
        for (int i = 0; i < PLANES; i++) begin
            if (r_rd_sel == 8'(i + 1))
                w_mem_dout = w_a_q[i];
        end
    end

    assign mem_dout = w_mem_dout;
    assign io_dout  = r_io_dout;
    assign busy     = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_vram_bank_ctrl.sv
// Self-checking bench for vram_bank_ctrl: directed cases plus randomized
// traffic compared against a plain array model of the plane memories.
`default_nettype none

module tb_vram_bank_ctrl;

    localparam int         NP   = 6;
    localparam int         NA   = 13;
    localparam int         NW   = 1 << NA;
    localparam logic [7:0] BASE = 8'hF1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            io_wr = 1'b0, io_rd = 1'b0;
    logic [7:0]      io_addr = 8'd0, io_din = 8'd0;
    logic [7:0]      io_dout;
    logic            mem_sel = 1'b0, mem_wr = 1'b0;
    logic [NA-1:0]   mem_addr = '0;
    logic [7:0]      mem_din = 8'd0;
    logic [7:0]      mem_dout;
    logic [NA-1:0]   vaddr = '0;
    logic [8*NP-1:0] vdata;
    logic            busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] m [NP][NW];
    logic [7:0] mb = 8'd0;
    logic [5:0] mm = 6'd0;

    vram_bank_ctrl #(.PLANES(NP), .AW(NA), .IO_BASE(BASE)) dut (
        .clk(clk), .reset_n(reset_n),
        .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr), .io_din(io_din), .io_dout(io_dout),
        .mem_sel(mem_sel), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .vaddr(vaddr), .vdata(vdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic [NA-1:0] a);
        if (mb >= 8'd1 && mb <= 8'(NP))
            return m[int'(mb) - 1][a];
        return 8'hFF;
    endfunction

    function automatic logic [63:0] exp_v(input logic [NA-1:0] a);
        logic [63:0] v = '0;
        for (int p = 0; p < NP; p++)
            v[8*p +: 8] = m[p][a];
        return v;
    endfunction

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        io_wr = 1'b1; io_addr = a; io_din = d;
        tick();
        io_wr = 1'b0;
        if (a == BASE) mb = d;
        if (a == BASE + 8'd1) mm = d[5:0];
    endtask

    task automatic io_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
        io_rd = 1'b1; io_addr = a;
        tick();
        io_rd = 1'b0;
        chk(tag, 64'(io_dout), 64'(exp));
    endtask

    task automatic cpu_write(input logic [NA-1:0] a, input logic [7:0] d);
        mem_sel = 1'b1; mem_wr = 1'b1; mem_addr = a; mem_din = d;
        tick();
        mem_sel = 1'b0; mem_wr = 1'b0;
        for (int p = 0; p < NP; p++)
            if (mm[p]) m[p][a] = d;
    endtask

    task automatic cpu_read(input string tag, input logic [NA-1:0] a);
        mem_sel = 1'b1; mem_wr = 1'b0; mem_addr = a;
        tick();
        mem_sel = 1'b0;
        chk(tag, 64'(mem_dout), 64'(exp_rd(a)));
    endtask

    task automatic vid(input string tag, input logic [NA-1:0] a);
        vaddr = a;
        tick();
        chk(tag, 64'(vdata), exp_v(a));
    endtask

    initial begin
        int n;
        logic [63:0] old_v;

        #23;
        chk("rst_io_dout", 64'(io_dout), 64'hFF);
        chk("rst_mem_dout", 64'(mem_dout), 64'hFF);
        chk("rst_vdata", 64'(vdata), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        reset_n = 1'b1;
        tick();
        io_read("rst_bank", BASE, 8'h00);
        io_read("rst_mask", BASE + 8'd1, 8'h00);

        // Give every plane location a known value
        io_write(BASE + 8'd1, 8'h3F);
        for (int a = 0; a < NW; a++)
            cpu_write(NA'(a), 8'($urandom));

        // Selective plane write
        cpu_write(13'h0010, 8'h5A);
        io_write(BASE + 8'd1, 8'h05);
        cpu_write(13'h0010, 8'hA5);
        io_write(BASE, 8'd1);
        cpu_read("p0_a5", 13'h0010);
        chk("p0_a5_const", 64'(mem_dout), 64'hA5);
        io_write(BASE, 8'd3);
        cpu_read("p2_a5", 13'h0010);
        chk("p2_a5_const", 64'(mem_dout), 64'hA5);
        io_write(BASE, 8'd2);
        cpu_read("p1_keep", 13'h0010);
        chk("p1_keep_const", 64'(mem_dout), 64'h5A);
        tick();
        chk("idle_ff", 64'(mem_dout), 64'hFF);

        // No plane selected
        io_write(BASE, 8'd0);
        cpu_read("bank0_ff", 13'h0010);
        io_write(BASE, 8'd7);
        cpu_read("bank7_ff", 13'h0010);
        chk("bank7_ff_const", 64'(mem_dout), 64'hFF);

        io_write(BASE + 8'd1, 8'hFF);
        io_read("mask_rd", BASE + 8'd1, 8'h3F);
        io_read("bad_port", 8'h00, 8'hFF);
        io_read("bank_rd", BASE, 8'h07);

        // Video read colliding with a CPU write returns old data first
        io_write(BASE + 8'd1, 8'h01);
        old_v = exp_v(13'h0010);
        vaddr = 13'h0010;
        mem_sel = 1'b1; mem_wr = 1'b1; mem_addr = 13'h0010; mem_din = ~old_v[7:0];
        tick();
        mem_sel = 1'b0; mem_wr = 1'b0;
        chk("vid_old", 64'(vdata), old_v);
        m[0][13'h0010] = ~old_v[7:0];
        tick();
        chk("vid_new", 64'(vdata), exp_v(13'h0010));

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0: io_write(BASE, 8'($urandom_range(0, 8)));
                1: io_write(BASE + 8'd1, 8'($urandom));
                2: cpu_write(NA'($urandom), 8'($urandom));
                3: cpu_read("rnd_rd", NA'($urandom));
                4: vid("rnd_vid", NA'($urandom));
                default: begin
                    io_read("rnd_io_bank", BASE, mb);
                    io_read("rnd_io_mask", BASE + 8'd1, 8'(mm));
                end
            endcase
        end

`ifdef VRAM_BANK_CTRL_CLEAR_EN
        io_write(BASE, 8'd1);
        cpu_write(13'h0005, 8'hC3);
        io_write(BASE + 8'd1, 8'h02);
        io_write(BASE + 8'd2, 8'h3C);
        n = 0;
        while (busy === 1'b1 && n < 10000) begin
            n++;
            if (n == 50) begin io_wr = 1'b1; io_addr = BASE + 8'd1; io_din = 8'h01; end
            if (n == 60) begin mem_sel = 1'b1; mem_wr = 1'b1; mem_addr = 13'h0005; mem_din = 8'h77; end
            if (n == 70) begin mem_sel = 1'b1; mem_wr = 1'b0; mem_addr = 13'h0005; end
            if (n == 80) begin io_wr = 1'b1; io_addr = BASE + 8'd2; io_din = 8'h99; end
            if (n == 100) begin io_rd = 1'b1; io_addr = BASE + 8'd2; end
            tick();
            if (n == 70) chk("busy_rd_ff", 64'(mem_dout), 64'hFF);
            if (n == 100) chk("busy_status", 64'(io_dout), 64'h80);
            io_wr = 1'b0; io_rd = 1'b0; mem_sel = 1'b0; mem_wr = 1'b0;
        end
        chk("busy_cycles", 64'(n), 64'd8192);
        mm = 6'h01;
        for (int a = 0; a < NW; a++) m[1][a] = 8'h3C;
        io_read("mask_during_clr", BASE + 8'd1, 8'h01);
        io_read("status_idle", BASE + 8'd2, 8'h00);
        io_write(BASE, 8'd2);
        cpu_read("clr_lo", 13'h0000);
        chk("clr_lo_const", 64'(mem_dout), 64'h3C);
        cpu_read("clr_hi", 13'h1FFF);
        chk("clr_hi_const", 64'(mem_dout), 64'h3C);
        io_write(BASE, 8'd1);
        cpu_read("p0_untouched", 13'h0005);
        chk("p0_untouched_const", 64'(mem_dout), 64'hC3);
        for (int i = 0; i < 20; i++) vid("clr_vid", NA'($urandom));

        // Reset while the clear counter sits at 100
        io_write(BASE + 8'd1, 8'h01);
        cpu_write(13'h0063, 8'h11);
        cpu_write(13'h0064, 8'h11);
        io_write(BASE + 8'd2, 8'hE7);
        chk("clr2_busy", 64'(busy), 64'h1);
        repeat (100) tick();
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_io_dout", 64'(io_dout), 64'hFF);
        chk("abort_vdata", 64'(vdata), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        mb = 8'd0; mm = 6'd0;
        for (int a = 0; a < 100; a++) m[0][a] = 8'hE7;
        chk("post_rst_busy", 64'(busy), 64'h0);
        io_write(BASE, 8'd1);
        cpu_read("abort_63", 13'h0063);
        chk("abort_63_const", 64'(mem_dout), 64'hE7);
        cpu_read("abort_64", 13'h0064);
        chk("abort_64_const", 64'(mem_dout), 64'h11);
        vid("abort_vid", 13'h0064);
`else
        io_write(BASE + 8'd1, 8'h01);
        io_write(BASE + 8'd2, 8'h3C);
        chk("noclr_busy", 64'(busy), 64'h0);
        io_read("noclr_status", BASE + 8'd2, 8'h00);
        cpu_write(13'h0020, 8'h6E);
        io_write(BASE, 8'd1);
        cpu_read("noclr_wr", 13'h0020);
        chk("noclr_wr_const", 64'(mem_dout), 64'h6E);
        vid("noclr_vid", 13'h0020);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vram_bank_ctrl.md
VRAM_BANK_CTRL -- requirements
Module: vram_bank_ctrl

Interface
REQ-001 SHALL have parameter PLANES, default 6, number of 8-bit VRAM planes (1..8).
REQ-002 SHALL have parameter AW, default 13, plane address width.
REQ-003 SHALL have parameter IO_BASE, default 8'hF1, I/O port of the read-bank register; IO_BASE+1 is the write-mask register; IO_BASE+2 is the clear/status port.
REQ-004 SHALL have port: clk  in  1  system clock; all state on rising edge.
REQ-005 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: io_wr, io_rd  in  1  CPU I/O write/read strobes, one cycle each; io_addr  in  8; io_din  in  8; io_dout  out  8.
REQ-007 SHALL have ports: mem_sel  in  1  CPU access inside VRAM window; mem_wr  in  1  write when high; mem_addr  in  AW; mem_din  in  8; mem_dout  out  8.
REQ-008 SHALL have ports: vaddr  in  AW  video fetch address; vdata  out  8*PLANES  plane i on bits [8i+7:8i].
REQ-009 SHALL have port: busy  out  1  clear engine active.

Function
REQ-010 SHALL hold one AW x 8 dual-port RAM per plane: port A is the CPU/clear port, port B is the read-only video port.
REQ-011 SHALL store io_din in rd_bank on io_wr at IO_BASE; rd_bank values 1..PLANES select plane rd_bank-1; any other value selects no plane.
REQ-012 SHALL store io_din[PLANES-1:0] in wr_mask on io_wr at IO_BASE+1; bit i enables writes to plane i.
REQ-013 SHALL write mem_din at mem_addr to every plane whose wr_mask bit is set when mem_sel and mem_wr are both high; wr_mask = 0 writes nothing.
REQ-014 SHALL present on mem_dout, one cycle after mem_sel with mem_wr low, the selected plane's byte; with no plane selected mem_dout SHALL be 8'hFF.
REQ-015 SHALL drive mem_dout = 8'hFF in every cycle not following a CPU read.
REQ-016 SHALL register vdata one cycle after vaddr for all planes simultaneously, independent of CPU, bank registers and clear engine.
REQ-017 SHALL register io_dout one cycle after io_rd: IO_BASE -> rd_bank; IO_BASE+1 -> wr_mask, zero-extended; IO_BASE+2 -> {busy, 7'b0}; other addresses -> 8'hFF.
REQ-018 SHALL give a write and a read at the same plane address in the same cycle old-data read behaviour on port A.
REQ-019 SHALL, for a video read and a CPU write to the same address in the same cycle, return the old data on vdata.

Reset
REQ-020 SHALL, while reset_n is low, force rd_bank = 0, wr_mask = 0, io_dout = 8'hFF, mem_dout = 8'hFF, vdata = 0, busy = 0, and clear state IDLE.
REQ-021 SHALL abort any clear in progress on reset; partially cleared contents are left as-is.
REQ-022 SHALL not initialise RAM contents on reset.

Configuration
REQ-023 SHALL compile the clear engine only when macro VRAM_BANK_CTRL_CLEAR_EN is defined.
REQ-024 SHALL, with the macro defined, run a two-state clear engine:
  - IDLE -> FILL on io_wr at IO_BASE+2; latch io_din as fill value and wr_mask as clear mask; counter = 0; busy = 1 from next cycle.
  - FILL writes the fill value to counter address in every masked plane, one address per cycle, for 2^AW cycles.
  - FILL -> IDLE after address 2^AW-1 is written; busy low the next cycle.
  - Clear mask = 0 still runs the full 2^AW cycles with no writes.
REQ-025 SHALL, while busy: ignore CPU memory writes; return mem_dout = 8'hFF for CPU reads; ignore io_wr at IO_BASE+2; accept rd_bank/wr_mask writes without affecting the running clear.
REQ-026 SHALL, without the macro: ignore writes to IO_BASE+2, tie busy to 0, and return 8'h00 on status reads.

Verification
REQ-027 SHALL cover: wr_mask=8'h05, write 8'hA5 at 13'h0010 -> planes 0 and 2 read 8'hA5 with rd_bank 1 and 3; plane 1 unchanged.
REQ-028 SHALL cover: rd_bank=0 or 7 (PLANES=6), CPU read -> mem_dout 8'hFF one cycle later.
REQ-029 SHALL cover: io_rd at IO_BASE+1 after writing 8'hFF -> io_dout 8'h3F; io_rd at 8'h00 -> 8'hFF.
REQ-030 SHALL cover: vaddr=13'h0010 while the CPU writes 13'h0010 -> vdata shows old byte, then new byte next cycle.
REQ-031 SHALL cover (CLEAR_EN): wr_mask=8'h02, write 8'h3C to IO_BASE+2:
  - busy high for exactly 8192 cycles.
  - Plane 1 reads 8'h3C at 13'h0000 and 13'h1FFF.
  - Plane 0 is untouched.
  - A CPU write during busy has no effect.
REQ-032 SHALL cover (CLEAR_EN): reset_n low at counter 100 -> busy 0 immediately; address 13'h0064 is not written.
